// File: rtl/disp_pkg.sv
// Shared definitions for the BCD display scan path: scan state encoding and
// the digit / decoded-pattern widths used by the controller and the decoder.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam int DEC_W = 10;
    localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_dec_1of10.sv
// Combinational BCD to 1-of-10 decoder. Value k sets bit k; codes 10..15
// produce all zeros so an invalid digit simply goes dark.
module bcd_dec_1of10
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [DEC_W-1:0] dec
);

    // one-hot decode of legal BCD codes, dark otherwise
    always_comb begin
        dec = '0;
        if (bcd <= 4'd9) begin
            dec = DEC_W'(1) << bcd;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed BCD digit scan controller. A new word is accepted over a
// valid/ready port into a shadow register and only becomes visible at a
// frame boundary (or immediately while idle). Each digit is driven for DWELL
// cycles followed by one blank cycle to avoid ghosting between digits.
// Optional build macro: LEADING_ZERO_BLANK_EN -- darkens leading zero digits
// (digit 0 always shown).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | outputs dark, waiting for enable; loads go straight to active
// ST_SCAN  | driving digit idx for DWELL cycles
// ST_BLANK | single dark cycle between digits; idx advances, frame commit
module bcd_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DWELL    = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [BCD_W*N_DIGITS-1:0] load_data,
    output logic [N_DIGITS-1:0]       dig_sel,
    output logic [DEC_W-1:0]          D,
    output logic                      frame_done,
    output logic                      err
);

    localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int WORD_W = BCD_W * N_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    scan_state_t         state, state_nx;
    logic [WORD_W-1:0]   active, active_nx;
    logic [WORD_W-1:0]   shadow, shadow_nx;
    logic                pending, pending_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [N_DIGITS-1:0] dig_sel_nx;
    logic [DEC_W-1:0]    d_nx;
    logic                frame_done_nx;
    logic                err_nx;
    logic                transfer;
    logic [BCD_W-1:0]    digit_mux;
    logic [DEC_W-1:0]    dec_out;
    logic                lz_blank;

    // a pending word blocks further loads until it has been committed
    assign load_ready = ~pending;
    assign transfer   = load_valid & ~pending;

    // next-state, buffer and commit decisions
    always_comb begin
        state_nx      = state;
        active_nx     = active;
        shadow_nx     = shadow;
        pending_nx    = pending;
        idx_nx        = idx;
        cnt_nx        = cnt;
        frame_done_nx = 1'b0;

        // while scanning, loads park in the shadow until the frame wraps
        if (transfer && (state != ST_IDLE)) begin
            shadow_nx  = load_data;
            pending_nx = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                // nothing is being displayed, so a new word can apply at once;
                // a word left pending by a mid-frame stop is flushed here too
                if (pending) begin
                    active_nx  = shadow;
                    pending_nx = 1'b0;
                end else if (transfer) begin
                    active_nx = load_data;
                    shadow_nx = load_data;
                end
                if (enable) begin
                    state_nx = ST_SCAN;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt == CNT_LAST) begin
                    state_nx      = ST_BLANK;
                    frame_done_nx = (idx == IDX_LAST);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                cnt_nx = '0;
                if (idx == IDX_LAST) begin
                    idx_nx = '0;
                    if (pending) begin
                        active_nx  = shadow;
                        pending_nx = 1'b0;
                    end
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
                state_nx = enable ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // select the digit to be shown next so the decoded pattern can be registered
    always_comb begin
        digit_mux = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == idx_nx) begin
                digit_mux = active_nx[BCD_W*i +: BCD_W];
            end
        end
    end

    bcd_dec_1of10 u_dec (
        .bcd (digit_mux),
        .dec (dec_out)
    );

    // leading-zero suppression: digit is dark if it and every digit above are zero
    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above & (active_nx[BCD_W*i +: BCD_W] == '0);
                if (IDX_W'(i) == idx_nx) begin
                    lz_blank = zero_above;
                end
            end
        end
`endif
    end

    // output patterns and invalid-digit flag for the upcoming cycle
    always_comb begin
        err_nx     = 1'b0;
        dig_sel_nx = '0;
        d_nx       = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (active_nx[BCD_W*i +: BCD_W] > 4'd9) begin
                err_nx = 1'b1;
            end
        end
        if (state_nx == ST_SCAN) begin
            dig_sel_nx = N_DIGITS'(1) << idx_nx;
            d_nx       = lz_blank ? '0 : dec_out;
        end
    end

    // state, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            dig_sel    <= '0;
            D          <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            active     <= active_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            dig_sel    <= dig_sel_nx;
            D          <= d_nx;
            frame_done <= frame_done_nx;
            err        <= err_nx;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl with N_DIGITS=4, DWELL=3 (frame = 16 cycles).
module tb_bcd_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  dig_sel;
    logic [9:0]  D;
    logic        frame_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        lv;
        logic [15:0] ld;
        logic [3:0]  sel;
        logic [9:0]  d;
        logic        fd;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t tbl[23];

    bcd_scan_ctrl #(.N_DIGITS(4), .DWELL(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dig_sel    (dig_sel),
        .D          (D),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] sel, input logic [9:0] d,
                              input logic fd, input logic rdy, input logic e);
        check({tag, " dig_sel"}, 32'(dig_sel), 32'(sel));
        check({tag, " D"}, 32'(D), 32'(d));
        check({tag, " frame_done"}, 32'(frame_done), 32'(fd));
        check({tag, " load_ready"}, 32'(load_ready), 32'(rdy));
        check({tag, " err"}, 32'(err), 32'(e));
    endtask

    // expected decoded pattern of digit d of word w
    function automatic logic [9:0] exp_dec(input logic [15:0] w, input int d);
        logic [3:0] v;
        v = w[4*d +: 4];
        if (v > 4'd9) return 10'd0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (w >> (4*d)) == 16'd0) return 10'd0;
`endif
        return 10'd1 << v;
    endfunction

    // one full frame with enable held; optional load at step ld_step, then a
    // stalled second load (16'h5555) held for the rest of the frame
    task automatic frame(input string tag, input logic [15:0] word, input logic exp_err,
                         input int ld_step, input logic [15:0] ld_word);
        for (int j = 0; j < 16; j++) begin
            int d;
            int ph;
            enable = 1'b1;
            if (j == ld_step) begin
                load_valid = 1'b1;
                load_data  = ld_word;
            end else if (ld_step >= 0 && j > ld_step) begin
                load_valid = 1'b1;
                load_data  = 16'h5555;
            end else begin
                load_valid = 1'b0;
                load_data  = 16'hFFFF;
            end
            step();
            d  = j / 4;
            ph = j % 4;
            check_outs(tag,
                       (ph < 3) ? 4'(1 << d) : 4'd0,
                       (ph < 3) ? exp_dec(word, d) : 10'd0,
                       (ph == 3 && d == 3),
                       (ld_step < 0 || j < ld_step),
                       exp_err);
        end
        load_valid = 1'b0;
    endtask

    task automatic set_vec(input int k, input logic en, input logic lv, input logic [15:0] ld,
                           input logic [3:0] sel, input logic [9:0] d, input logic fd,
                           input logic rdy, input logic e);
        tbl[k].en  = en;
        tbl[k].lv  = lv;
        tbl[k].ld  = ld;
        tbl[k].sel = sel;
        tbl[k].d   = d;
        tbl[k].fd  = fd;
        tbl[k].rdy = rdy;
        tbl[k].err = e;
    endtask

    initial begin
        // first frame after reset with active = 0000: digit j/4, blank every 4th
        for (int j = 0; j < 16; j++) begin
            set_vec(j, 1'b1, 1'b0, 16'h0000,
                    ((j % 4) < 3) ? 4'(1 << (j / 4)) : 4'd0,
                    ((j % 4) < 3) ? 10'h001 : 10'h000,
                    (j == 15), 1'b1, 1'b0);
        end
        // enable dropped mid-dwell: dwell completes, blank, then idle
        set_vec(16, 1'b1, 1'b0, 16'h0000, 4'b0001, 10'h001, 1'b0, 1'b1, 1'b0);
        set_vec(17, 1'b0, 1'b0, 16'h0000, 4'b0001, 10'h001, 1'b0, 1'b1, 1'b0);
        set_vec(18, 1'b0, 1'b0, 16'h0000, 4'b0001, 10'h001, 1'b0, 1'b1, 1'b0);
        set_vec(19, 1'b0, 1'b0, 16'h0000, 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        set_vec(20, 1'b0, 1'b0, 16'h0000, 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        // idle load applies immediately and ready stays high
        set_vec(21, 1'b0, 1'b1, 16'h1234, 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        set_vec(22, 1'b0, 1'b0, 16'hFFFF, 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);

        rst        = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        step();
        step();
        check_outs("reset", 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 23; k++) begin
            enable     = tbl[k].en;
            load_valid = tbl[k].lv;
            load_data  = tbl[k].ld;
            step();
            check_outs($sformatf("vec%0d", k), tbl[k].sel, tbl[k].d, tbl[k].fd,
                       tbl[k].rdy, tbl[k].err);
        end

        frame("f1234", 16'h1234, 1'b0, -1, 16'h0000);
        frame("f1234_ld0987", 16'h1234, 1'b0, 5, 16'h0987);
        frame("f0987", 16'h0987, 1'b0, -1, 16'h0000);
        frame("f0987_ld00A5", 16'h0987, 1'b0, 5, 16'h00A5);
        frame("f00A5", 16'h00A5, 1'b1, -1, 16'h0000);

        // reset mid-dwell with a load pending
        enable     = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h3333;
        step();
        check_outs("pre_rst0", 4'b0001, exp_dec(16'h00A5, 0), 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        step();
        check_outs("pre_rst1", 4'b0001, exp_dec(16'h00A5, 0), 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check_outs("mid_rst", 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        rst    = 1'b0;
        enable = 1'b0;
        step();
        check_outs("post_rst_idle", 4'b0000, 10'h000, 1'b0, 1'b1, 1'b0);
        frame("f_after_rst", 16'h0000, 1'b0, -1, 16'h0000);

        frame("f0000_ld0040", 16'h0000, 1'b0, 5, 16'h0040);
        frame("f0040", 16'h0040, 1'b0, -1, 16'h0000);
        frame("f0040_ld0000", 16'h0040, 1'b0, 5, 16'h0000);
        frame("f0000", 16'h0000, 1'b0, -1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-1-of-10 decoder across `N_DIGITS` digit positions. It accepts a packed multi-digit BCD word through a valid/ready load port and double-buffers it so updates apply only at frame boundaries. It then cycles through the digits, driving a one-hot digit select plus the decoded 1-of-10 pattern for the selected digit. It sits between the counter/arithmetic logic that produces BCD values and the display/indicator drivers.

## Interface
- `N_DIGITS`, 4, number of digit positions scanned (≥1)
- `DWELL`, 1000, clock cycles each digit is driven (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `enable`  in  1  scan enable
- `load_valid`  in  1  load request
- `load_ready`  out  1  controller can accept a load
- `load_data`  in  4*N_DIGITS  packed BCD; digit i at [4i+3:4i], i=0 least significant
- `dig_sel`  out  N_DIGITS  one-hot digit select, active-high
- `D`  out  10  decoded 1-of-10 pattern for selected digit
- `frame_done`  out  1  one-cycle pulse at end of each full scan
- `err`  out  1  high while any active digit holds 10..15

## Operation
- Registers: `active` (displayed word), `shadow` (pending word), `pending` flag, digit index `idx`, dwell counter `cnt` (width clog2(DWELL), min 1).
- Reset values: state IDLE; `active`, `shadow`, `idx`, `cnt` = 0; `pending` = 0; `load_ready` = 1; `dig_sel`, `D`, `frame_done`, `err` = 0.
- Load handshake: transfer when `load_valid & load_ready`; `load_data` → `shadow`, `pending` ← 1, `load_ready` = ~`pending`. `load_data` ignored when not transferring.
- Commit: `shadow` → `active`, `pending` ← 0, `err` recomputed from new `active`. Occurs (a) the cycle after a transfer while in IDLE, or (b) in the BLANK cycle where `idx` wraps N_DIGITS-1 → 0.
- States:
  - IDLE: `dig_sel`=0, `D`=0. `enable`=1 → SCAN with `idx`=0, `cnt`=0.
  - SCAN: `dig_sel`=1<<`idx`, `D`=decode(`active[idx]`). `cnt` increments; at `cnt`=DWELL-1 → BLANK.
  - BLANK (exactly 1 cycle, anti-ghosting): `dig_sel`=0, `D`=0, `idx` advances with wrap. At wrap: `frame_done`=1 and commit if `pending`. Next: `enable`=1 → SCAN (`cnt`=0), else IDLE.
- `enable` is sampled only in IDLE and BLANK; deasserting mid-dwell completes the current dwell.
- Invalid digit (10..15): `D`=0 during its dwell; `dig_sel` still driven.
- Reset mid-operation: all registers return to reset values; a pending load is discarded.

## Timing
- All outputs registered.
- `enable` high in IDLE at cycle t → `dig_sel` valid at t+1.
- Digit period DWELL+1 cycles; frame period N_DIGITS*(DWELL+1).
- IDLE load: transfer at t, `active` updated and `load_ready` high again at t+1.
- Scanning load: `load_ready` low from cycle after transfer until the cycle after the wrap BLANK.
- A transfer in the same cycle as a commit is impossible (`load_ready`=0 whenever `pending`=1).

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit i with value 0 and all digits above i also 0 gets `D`=0. Digit 0 is never blanked. `dig_sel` is unaffected.
- Not defined: every digit is decoded as stored.

## Structure
- Shared package/include `disp_pkg`: state encoding (IDLE, SCAN, BLANK), `DEC_W`=10, `BCD_W`=4.
- Sub-module `bcd_dec_1of10`: combinational decoder, value k → bit k set; 10..15 → all zeros (no X). Instantiated once and fed by the `idx` mux.

## Test plan
- N_DIGITS=4, DWELL=3; reset, then `enable`=1 → `dig_sel` sequence 0001×3, 0000, 0010×3, 0000 …; `D`=10'b0000000001 throughout; `frame_done` pulses every 16 cycles.
- IDLE load `load_data`=16'h1234 → next cycle `active`=1234. Scan shows `D`=bit4 (digit0), bit3, bit2, bit1.
- Mid-frame load 16'h0987 during digit 1 → `load_ready` low, old value displayed until wrap, new value from next digit 0. Second `load_valid` is stalled.
- Load 16'h00A5 → `err`=1 after commit; digit 1 dwell has `D`=0 with `dig_sel`=0010.
- With `LEADING_ZERO_BLANK_EN` defined, load 16'h0040 → digits 3 and 2 `D`=0; digit 1 `D`=bit4; digit 0 `D`=bit0. Load 16'h0000 → digit 0 `D`=bit0.
- `rst` asserted mid-dwell with a load pending → next cycle all outputs at reset values, `load_ready`=1, `active`=0.
